// File: rtl/bcd_display_scanner_pkg.sv
// rtl/bcd_display_scanner_pkg.sv - shared FSM encoding, glyph constants and scan defaults
package bcd_display_scanner_pkg;

  // 1 ms per digit slot at 50 MHz, with a short dark gap to stop ghosting
  localparam int DEFAULT_SCAN_PERIOD  = 50000;
  localparam int DEFAULT_BLANK_CYCLES = 500;

  // Scan FSM: each digit slot is a dark gap followed by the lit phase
  typedef enum logic [1:0] {
    U_BLANK = 2'd0,
    U_ON    = 2'd1,
    T_BLANK = 2'd2,
    T_ON    = 2'd3
  } scan_state_t;

  // Segment glyphs, active-low, bit order g f e d c b a = [6:0]
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  // Anode patterns, active-low, [0] units, [1] tens
  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;

  // A captured nibble outside 0..9 is not valid BCD
  function automatic logic bcd_invalid(input logic [3:0] nib);
    return nib > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD nibble to active-low 7-segment glyph
module bcd_to_7seg
  import bcd_display_scanner_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Standard 0-9 glyphs; anything above 9 shows a dash so bad data is visible
  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - two-digit multiplexed 7-segment scanner with blanking gaps
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int SCAN_PERIOD   = DEFAULT_SCAN_PERIOD,
  parameter int BLANK_CYCLES  = DEFAULT_BLANK_CYCLES,
  parameter int BLANK_LEADING = 1
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic [7:0] bcd_in,
  input  logic       load,
  output logic [6:0] seg_out,
  output logic [1:0] an_out,
  output logic       err
);

  localparam int               CNT_W      = $clog2(SCAN_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_PERIOD - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  scan_state_t      state;
  scan_state_t      state_next;
  logic [CNT_W-1:0] scan_cnt;
  logic             cnt_wrap;
  logic [7:0]       held;
  logic [6:0]       units_seg;
  logic [6:0]       tens_seg;
  logic [6:0]       seg_next;
  logic [1:0]       an_next;
  logic             held_bad;

  assign cnt_wrap = (scan_cnt == CNT_LAST);
  assign held_bad = bcd_invalid(held[7:4]) || bcd_invalid(held[3:0]);

  bcd_to_7seg u_units_dec (
    .digit (held[3:0]),
    .seg   (units_seg)
  );

  bcd_to_7seg u_tens_dec (
    .digit (held[7:4]),
    .seg   (tens_seg)
  );

  // Free-running slot counter; independent of load so refresh rate stays fixed
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      scan_cnt <= '0;
    end else if (cnt_wrap) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + CNT_ONE;
    end
  end

  // Held digit pair; a load always wins, otherwise the value is kept
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      held <= 8'h00;
    end else if (load) begin
      held <= bcd_in;
    end
  end

  // Scan FSM state register
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      state <= U_BLANK;
    end else begin
      state <= state_next;
    end
  end

  // Next state: gap ends at BLANK_CYCLES-1, lit phase ends at counter wrap
  always_comb begin
    state_next = state;
    case (state)
      U_BLANK: if (scan_cnt == BLANK_LAST) state_next = U_ON;
      U_ON:    if (cnt_wrap)               state_next = T_BLANK;
      T_BLANK: if (scan_cnt == BLANK_LAST) state_next = T_ON;
      T_ON:    if (cnt_wrap)               state_next = U_BLANK;
      default:                             state_next = U_BLANK;
    endcase
  end

  // Output decode from the current state and held data, registered below
  always_comb begin
    seg_next = SEG_OFF;
    an_next  = AN_OFF;
    case (state)
      U_ON: begin
        an_next  = AN_UNITS;
        seg_next = units_seg;
      end
      T_ON: begin
        if ((BLANK_LEADING != 0) && (held[7:4] == 4'd0)) begin
          an_next  = AN_OFF;
          seg_next = SEG_OFF;
        end else begin
          an_next  = AN_TENS;
          seg_next = tens_seg;
        end
      end
      default: begin
        an_next  = AN_OFF;
        seg_next = SEG_OFF;
      end
    endcase
  end

  // Anode and segments are registered together so they can never disagree
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      an_out  <= AN_OFF;
      seg_out <= SEG_OFF;
    end else begin
      an_out  <= an_next;
      seg_out <= seg_next;
    end
  end

  // Sticky error: set the edge after an invalid nibble lands in the held register
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      err <= 1'b0;
    end else if (held_bad) begin
      err <= 1'b1;
    end
  end

endmodule
